// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage payload layouts, NOP encoding and
// the occupancy encoding used by every pipeline stage register.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_st_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: producer side (in_*)
// and consumer side (out_*). slave is the stage, master is its environment.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready backpressure, optional skid entry
// (registered in_ready), flush-to-bubble and a saturating flush counter.
//
// state | meaning
// EMPTY | main and skid entries invalid, out_data shows the bubble value
// FULL  | main entry valid, skid entry invalid
// SKID  | main and skid entries valid, producer is held off
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit              SKID_EN    = 1'b1,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_st_e         st, st_nxt;
  logic              in_xfer, out_xfer;
  logic [DATA_W-1:0] m_data, s_data;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= EMPTY;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    if (flush) begin
      st_nxt = EMPTY;
    end else begin
      case (st)
        EMPTY:   if (in_xfer) st_nxt = FULL;
        FULL: begin
          if (out_xfer && !in_xfer)              st_nxt = EMPTY;
          else if (in_xfer && !out_xfer && SKID_EN) st_nxt = SKID;
        end
        SKID:    if (out_xfer) st_nxt = FULL;
        default: st_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = (st != EMPTY);
    bus.out_data  = m_data;
  end

  // m_data falls back to the bubble whenever the main entry empties, so the
  // consumer never sees a stale payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= BUBBLE_VAL;
    end else if (flush) begin
      m_data <= BUBBLE_VAL;
    end else begin
      case (st)
        EMPTY: if (in_xfer) m_data <= bus.in_data;
        FULL: begin
          if (in_xfer && out_xfer) m_data <= bus.in_data;
          else if (out_xfer)       m_data <= BUBBLE_VAL;
        end
        SKID:    if (out_xfer) m_data <= s_data;
        default: m_data <= BUBBLE_VAL;
      endcase
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_data <= BUBBLE_VAL;
        end else if (!flush && (st == FULL) && in_xfer && !out_xfer) begin
          s_data <= bus.in_data;
        end
      end

      // Registered so the consumer's ready never reaches the producer in
      // the same cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (st_nxt != SKID);
        end
      end

      assign bus.in_ready = in_ready_q;
    end else begin : g_no_skid
      assign s_data       = BUBBLE_VAL;
      assign bus.in_ready = bus.out_ready | ~bus.out_valid;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid build (CNT_W=4, NOP bubble) checked with a
// scoreboard, plus a combinational-ready build checked cycle by cycle.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int          DW    = 32;
  localparam logic [31:0] BUB_A = NOP_INSTR;
  localparam logic [31:0] BUB_B = '0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_a, flush_b;
  logic [3:0]  fcnt_a;
  logic [15:0] fcnt_b;

  pipe_stage_skid_if #(.DATA_W(DW)) if_a ();
  pipe_stage_skid_if #(.DATA_W(DW)) if_b ();

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB_A), .SKID_EN(1'b1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .bus(if_a), .flush_cnt(fcnt_a)
  );

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB_B), .SKID_EN(1'b0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .bus(if_b), .flush_cnt(fcnt_b)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          fc_model = 0;
  logic [31:0] sb[$];

  // Drives one cycle on DUT A and records what the handshake will do at the
  // coming edge; accepted non-flushed inputs go onto the scoreboard.
  task automatic cyc_a(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                       output bit ix, output bit ox, output logic ov, output logic [31:0] od);
    @(negedge clk);
    if_a.in_valid  = iv;
    if_a.in_data   = iv ? id : 'x;
    if_a.out_ready = ordy;
    flush_a        = fl;
    #1;
    ov = if_a.out_valid;
    od = if_a.out_data;
    ix = iv && (if_a.in_ready === 1'b1);
    ox = (ov === 1'b1) && ordy;
    if (ix && !fl) sb.push_back(id);
    if (fl && fc_model < 15) fc_model++;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (if_a.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", if_a.out_valid); else n_pass++;
    n_total++; if (if_a.out_data !== BUB_A) $display("FAIL rst_out_data got=%h exp=%h", if_a.out_data, BUB_A); else n_pass++;
    n_total++; if (fcnt_a !== 4'd0) $display("FAIL rst_flush_cnt got=%0d exp=0", fcnt_a); else n_pass++;
    n_total++; if (if_b.out_data !== BUB_B) $display("FAIL rst_out_data_b got=%h exp=%h", if_b.out_data, BUB_B); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (if_a.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", if_a.in_ready); else n_pass++;
    n_total++; if (if_b.in_ready !== 1'b1) $display("FAIL rst_in_ready_b got=%b exp=1", if_b.in_ready); else n_pass++;
  endtask

  task automatic test_streaming();
    bit ix, ox; logic ov; logic [31:0] od, want;
    for (int i = 0; i < 9; i++) begin
      cyc_a(i < 8, 32'(i + 1), 1'b1, 1'b0, ix, ox, ov, od);
      if (i < 8) begin
        n_total++; if (if_a.in_ready !== 1'b1) $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, if_a.in_ready); else n_pass++;
      end
      if (i >= 1) begin
        n_total++; if (ov !== 1'b1) $display("FAIL stream_latency cyc=%0d out_valid got=%b exp=1", i, ov); else n_pass++;
      end
      if (ox) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL stream_extra got=%h exp=<none>", od);
        else begin want = sb.pop_front(); if (od !== want) $display("FAIL stream_data got=%h exp=%h", od, want); else n_pass++; end
      end
    end
    n_total++; if (sb.size() != 0) $display("FAIL stream_drain left got=%0d exp=0", sb.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ix, ox; logic ov; logic [31:0] od, want;
    logic [31:0] bp [3];
    int idx = 0;
    bp[0] = 32'h11; bp[1] = 32'h22; bp[2] = 32'h33;
    for (int c = 0; c < 4; c++) begin
      cyc_a(idx < 3, (idx < 3) ? bp[idx] : 32'h0, 1'b0, 1'b0, ix, ox, ov, od);
      if (ix) idx++;
      if (c >= 2) begin
        n_total++; if (if_a.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, if_a.in_ready); else n_pass++;
        n_total++; if (od !== 32'h11) $display("FAIL bp_hold_data cyc=%0d got=%h exp=00000011", c, od); else n_pass++;
      end
    end
    for (int t = 0; t < 20 && (sb.size() > 0 || idx < 3); t++) begin
      cyc_a(idx < 3, (idx < 3) ? bp[idx] : 32'h0, 1'b1, 1'b0, ix, ox, ov, od);
      if (ix) idx++;
      if (ox) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL bp_extra got=%h exp=<none>", od);
        else begin want = sb.pop_front(); if (od !== want) $display("FAIL bp_data got=%h exp=%h", od, want); else n_pass++; end
      end
    end
    n_total++; if (sb.size() != 0 || idx != 3) $display("FAIL bp_drain_timeout left got=%0d sent=%0d exp=0/3", sb.size(), idx); else n_pass++;
  endtask

  task automatic test_random();
    bit ix, ox, prev_ox; logic ov, prev_ov; logic [31:0] od, prev_od, want;
    logic [31:0] d = 32'h100;
    prev_ov = 1'b0; prev_ox = 1'b0; prev_od = '0;
    for (int i = 0; i < 60; i++) begin
      cyc_a(1'($urandom_range(0, 1)), d, ($urandom % 4) != 0, 1'b0, ix, ox, ov, od);
      if (ix) d++;
      if (prev_ov && !prev_ox) begin
        n_total++; if (ov !== 1'b1 || od !== prev_od) $display("FAIL rand_stable cyc=%0d got=%b/%h exp=1/%h", i, ov, od, prev_od); else n_pass++;
      end
      if (ov === 1'b0) begin
        n_total++; if (od !== BUB_A) $display("FAIL rand_bubble cyc=%0d got=%h exp=%h", i, od, BUB_A); else n_pass++;
      end
      if (ox) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL rand_extra got=%h exp=<none>", od);
        else begin want = sb.pop_front(); if (od !== want) $display("FAIL rand_data got=%h exp=%h", od, want); else n_pass++; end
      end
      prev_ov = ov; prev_ox = ox; prev_od = od;
    end
    for (int t = 0; t < 10 && sb.size() > 0; t++) begin
      cyc_a(1'b0, 32'h0, 1'b1, 1'b0, ix, ox, ov, od);
      if (ox) begin
        n_total++;
        want = sb.pop_front();
        if (od !== want) $display("FAIL rand_drain_data got=%h exp=%h", od, want); else n_pass++;
      end
    end
    n_total++; if (sb.size() != 0) $display("FAIL rand_drain_timeout left got=%0d exp=0", sb.size()); else n_pass++;
  endtask

  task automatic test_flush();
    bit ix, ox; logic ov; logic [31:0] od;
    cyc_a(1'b1, 32'h0A, 1'b0, 1'b0, ix, ox, ov, od);
    cyc_a(1'b1, 32'h0B, 1'b0, 1'b0, ix, ox, ov, od);
    cyc_a(1'b1, 32'h44, 1'b0, 1'b1, ix, ox, ov, od);
    sb.delete();
    @(posedge clk); #1;
    n_total++; if (if_a.out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", if_a.out_valid); else n_pass++;
    n_total++; if (if_a.out_data !== BUB_A) $display("FAIL flush_out_data got=%h exp=%h", if_a.out_data, BUB_A); else n_pass++;
    n_total++; if (if_a.in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", if_a.in_ready); else n_pass++;
    n_total++; if (fcnt_a !== 4'(fc_model)) $display("FAIL flush_cnt got=%0d exp=%0d", fcnt_a, fc_model); else n_pass++;
    cyc_a(1'b1, 32'h55, 1'b1, 1'b0, ix, ox, ov, od);
    cyc_a(1'b1, 32'h66, 1'b0, 1'b1, ix, ox, ov, od);
    sb.delete();
    @(posedge clk); #1;
    n_total++; if (if_a.out_valid !== 1'b0) $display("FAIL flush_accept_drop got=%b exp=0", if_a.out_valid); else n_pass++;
    n_total++; if (fcnt_a !== 4'(fc_model)) $display("FAIL flush_cnt2 got=%0d exp=%0d", fcnt_a, fc_model); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b0, 32'h0, 1'b1, 1'b0, ix, ox, ov, od);
      n_total++; if (ov !== 1'b0) $display("FAIL flush_ghost cyc=%0d got=%b/%h exp=0", i, ov, od); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ix, ox; logic ov; logic [31:0] od;
    cyc_a(1'b1, 32'h0A, 1'b0, 1'b0, ix, ox, ov, od);
    cyc_a(1'b1, 32'h0B, 1'b0, 1'b0, ix, ox, ov, od);
    @(posedge clk); #2;
    n_total++; if (if_a.in_ready !== 1'b0) $display("FAIL mid_skid_in_ready got=%b exp=0", if_a.in_ready); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (if_a.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got=%b exp=0", if_a.out_valid); else n_pass++;
    n_total++; if (if_a.out_data !== BUB_A) $display("FAIL mid_rst_out_data got=%h exp=%h", if_a.out_data, BUB_A); else n_pass++;
    n_total++; if (fcnt_a !== 4'd0) $display("FAIL mid_rst_flush_cnt got=%0d exp=0", fcnt_a); else n_pass++;
    sb.delete();
    fc_model = 0;
    if_a.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (if_a.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got=%b exp=1", if_a.in_ready); else n_pass++;
  endtask

  task automatic test_saturation();
    bit ix, ox; logic ov; logic [31:0] od;
    for (int i = 0; i < 20; i++) begin
      cyc_a(1'b0, 32'h0, 1'b0, 1'b1, ix, ox, ov, od);
      @(posedge clk); #1;
      n_total++; if (fcnt_a !== 4'(fc_model)) $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", i, fcnt_a, fc_model); else n_pass++;
    end
    @(negedge clk);
    flush_a = 1'b0;
    @(posedge clk); #1;
    n_total++; if (fcnt_a !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", fcnt_a); else n_pass++;
  endtask

  task automatic test_no_skid();
    @(negedge clk);
    if_b.in_valid = 1'b1; if_b.in_data = 32'h55; if_b.out_ready = 1'b0;
    #1;
    n_total++; if (if_b.in_ready !== 1'b1) $display("FAIL ns_empty_ready got=%b exp=1", if_b.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if_b.out_valid !== 1'b1 || if_b.out_data !== 32'h55) $display("FAIL ns_latency got=%b/%h exp=1/00000055", if_b.out_valid, if_b.out_data); else n_pass++;
    @(negedge clk);
    if_b.in_data = 32'h66;
    #1;
    n_total++; if (if_b.in_ready !== 1'b0) $display("FAIL ns_stall_ready got=%b exp=0", if_b.in_ready); else n_pass++;
    if_b.out_ready = 1'b1;
    #1;
    n_total++; if (if_b.in_ready !== 1'b1) $display("FAIL ns_comb_ready got=%b exp=1", if_b.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if_b.out_data !== 32'h66) $display("FAIL ns_next_data got=%h exp=00000066", if_b.out_data); else n_pass++;
    @(negedge clk);
    if_b.in_valid = 1'b0; if_b.out_ready = 1'b0; flush_b = 1'b1;
    @(posedge clk); #1;
    n_total++; if (if_b.out_valid !== 1'b0 || if_b.out_data !== BUB_B) $display("FAIL ns_flush_out got=%b/%h exp=0/%h", if_b.out_valid, if_b.out_data, BUB_B); else n_pass++;
    n_total++; if (if_b.in_ready !== 1'b1) $display("FAIL ns_flush_ready got=%b exp=1", if_b.in_ready); else n_pass++;
    n_total++; if (fcnt_b !== 16'd1) $display("FAIL ns_flush_cnt got=%0d exp=1", fcnt_b); else n_pass++;
    @(negedge clk);
    flush_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    test_saturation();
    test_no_skid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register. It is the successor to the fixed 2x32-bit IF/ID latch and is used for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds a valid/ready handshake for backpressure and stall.
- Adds an optional skid entry, so in_ready is a registered signal and breaks the ready timing path.
- Adds flush-to-bubble with a programmable bubble value and a saturating flush counter for perf monitoring.
- Sits between two pipeline stages: the producer drives in_*, the consumer drives out_ready.

Parameters:
DATA_W, 64, payload width (e.g. PC concatenated with instruction).
BUBBLE_VAL, 0, value out_data takes on reset and flush (e.g. a NOP encoding in the low bits).
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 16, width of the flush_cnt counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
flush  input  1  synchronous flush; kills all held entries.
in_valid  input  1  producer has data.
in_ready  output  1  stage can accept data this cycle.
in_data  input  DATA_W  producer payload.
out_valid  output  1  out_data holds a live entry.
out_ready  input  1  consumer accepts this cycle.
out_data  output  DATA_W  payload presented to the consumer.
flush_cnt  output  CNT_W  number of flush cycles since reset, saturating.

Behaviour:
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - All state updates occur on the rising clk edge.
- Reset (asynchronous, rst=1):
  - main and skid entries invalid.
  - out_valid=0, out_data=BUBBLE_VAL, flush_cnt=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Latency: 1 cycle in to out when the stage is empty. No combinational path in_data->out_data.

SKID_EN=1 state machine (main register M, skid register S):
- EMPTY (M invalid, S invalid):
  - in_ready=1.
  - Input transfer -> M=in_data, go to FULL.
- FULL (M valid, S invalid):
  - in_ready=1.
  - Input and output transfer together -> M=in_data, stay in FULL.
  - Output transfer only -> EMPTY.
  - Input transfer only -> S=in_data, go to SKID.
  - No transfer -> hold.
- SKID (M and S valid):
  - in_ready=0.
  - Output transfer -> M=S, S invalid, go to FULL.
- in_ready is driven from a flop: it equals the registered "S invalid" and has no combinational dependence on out_ready.
- Ordering is strictly FIFO; no entry is ever lost or duplicated.

SKID_EN=0:
- in_ready = out_ready | ~out_valid (combinational).
- S is not instantiated; only EMPTY and FULL exist.

Flush:
- Flush has priority over every transfer in the same cycle. Next state = EMPTY and out_data=BUBBLE_VAL.
- An input accepted in the flush cycle is discarded.
- An output transfer in the flush cycle still counts as consumed, because the consumer sampled it before the edge.
- in_ready is 1 in the cycle after flush, in both modes.
- flush_cnt increments on every cycle with flush=1 and saturates at all-ones (no wrap).
- Flush together with reset: reset wins.

Other boundary rules:
- When M is invalid, out_data=BUBBLE_VAL. It never shows stale payload.
- in_data is sampled only on an input transfer. X on in_data while in_valid=0 must not propagate to out_data.
- out_ready may toggle arbitrarily. out_valid, once high, stays high with stable out_data until an output transfer or flush (AXI-style stability).

Decomposition:
- Shared package pipe_pkg:
  - Stage payload typedefs (if_id_t = {pc[31:0], instr[31:0]}, etc.).
  - NOP_INSTR constant, 32'h00000013.
  - Stage-state encoding constants (EMPTY, FULL, SKID).
- No sub-module required. The flush counter may be factored into sat_counter (param W) if other perf counters reuse it.

Test Plan:
1. Reset mid-operation: SKID state with M=0xA, S=0xB, assert rst -> out_valid=0, out_data=BUBBLE_VAL, flush_cnt=0 immediately; in_ready=1 after rst falls.
2. Streaming (SKID_EN=1): in_valid=1 with data 1,2,3,... and out_ready=1 every cycle -> out_data sequence 1,2,3,... one cycle later, in_ready held at 1.
3. Backpressure: push 0x11, 0x22, 0x33 with out_ready=0 -> 0x11 in M, 0x22 in S, in_ready=0 so 0x33 is held by the producer. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order, no loss or duplication.
4. Flush priority: in SKID state, assert flush with in_valid=1 (data 0x44) -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1, 0x44 never emitted, flush_cnt +1.
5. Counter saturation with CNT_W=4: hold flush for 20 cycles -> flush_cnt reaches 15 and stays at 15.
6. SKID_EN=0 build: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally, and new data appears on out_data after 1 cycle.
